// File: rtl/aes_in_loader.sv
// -----------------------------------------------------------------------------
// aes_in_loader
//
// Byte-serial input framer in front of a combinational AES-128 core. A tagged
// byte stream is collected into a 128-bit key register and a 128-bit plaintext
// register. Each complete {data, key} pair is offered to the core with a
// valid/ready handshake. The key is kept across blocks so one key load can
// serve many plaintext blocks (KEY_STICKY=1), or it is dropped after every
// issued block (KEY_STICKY=0).
//
// Byte order is big-endian: byte n (n = 0..15) occupies bits [8n:8n+7] of the
// ascending-range output vectors, so byte 0 is the most significant byte.
//
// Parameters
//   KEY_STICKY  1: key stays valid after a pair is issued; 0: key is invalidated
//   CNT_W       width of the issued-pair counter blk_cnt
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   in_byte    in   input byte
//   in_is_key  in   1: in_byte is a key byte, 0: plaintext byte
//   in_valid   in   in_byte / in_is_key valid
//   in_ready   out  loader accepts the byte this cycle
//   data_out   out  assembled plaintext [0:127]
//   key_out    out  assembled key [0:127]
//   out_valid  out  data_out / key_out form a complete pair
//   out_ready  in   consumer takes the pair
//   key_valid  out  16 key bytes loaded since last invalidation
//   blk_cnt    out  number of pairs issued, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module aes_in_loader #(
    parameter bit KEY_STICKY = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_byte,
    input  logic             in_is_key,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [0:127]     data_out,
    output logic [0:127]     key_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             key_valid,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,   // gathering key and/or data bytes
        WAIT_KEY = 2'd1,   // data block full, waiting for a complete key
        OUTPUT   = 2'd2    // pair offered to the core
    } state_t;

    state_t     state;
    logic [3:0] d_idx;     // next plaintext byte position
    logic [3:0] k_idx;     // next key byte position

    logic accept;
    logic key_acc;
    logic data_acc;
    logic key_done;
    logic data_done;

    // in_ready is combinational so that in WAIT_KEY key bytes keep flowing
    // while data bytes stall on the same cycle they are presented.
    always_comb begin
        // NOTE: default assignment first so no path leaves in_ready unassigned
        // (an unassigned path in always_comb would infer a latch).
        in_ready = 1'b0;
        case (state)
            COLLECT:  in_ready = 1'b1;
            WAIT_KEY: in_ready = in_is_key;
            default:  in_ready = 1'b0;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign key_acc   = accept & in_is_key;
    assign data_acc  = accept & ~in_is_key;
    assign key_done  = key_acc  & (k_idx == 4'd15);
    assign data_done = data_acc & (d_idx == 4'd15);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the wide key/data registers are reset on purpose: the
            // outputs must read zero after reset, not stale bytes.
            data_out  <= '0;
            key_out   <= '0;
            out_valid <= 1'b0;
            key_valid <= 1'b0;
            blk_cnt   <= '0;
            d_idx     <= 4'd0;
            k_idx     <= 4'd0;
            state     <= COLLECT;
        end else begin
            // Key bytes: independent of the data index, legal in COLLECT and
            // WAIT_KEY. Starting a new load drops the old key immediately.
            if (key_acc) begin
                key_out[{k_idx, 3'b000} +: 8] <= in_byte;
                k_idx                         <= k_idx + 4'd1;
                if (k_idx == 4'd0)
                    key_valid <= 1'b0;
                if (key_done)
                    key_valid <= 1'b1;
            end

            // Data bytes: only accepted in COLLECT; a key reload does not
            // disturb a partially filled data block.
            if (data_acc) begin
                data_out[{d_idx, 3'b000} +: 8] <= in_byte;
                d_idx                          <= d_idx + 4'd1;
            end

            case (state)
                COLLECT: begin
                    if (data_done) begin
                        if (key_valid || key_done) begin
                            state     <= OUTPUT;
                            out_valid <= 1'b1;
                        end else begin
                            state <= WAIT_KEY;
                        end
                    end
                end

                WAIT_KEY: begin
                    if (key_done) begin
                        state     <= OUTPUT;
                        out_valid <= 1'b1;
                    end
                end

                OUTPUT: begin
                    // in_ready is 0 here, so data_out/key_out cannot change
                    // while the pair is offered.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        blk_cnt   <= blk_cnt + CNT_W'(1);
                        if (!KEY_STICKY)
                            key_valid <= 1'b0;
                        state <= COLLECT;
                    end
                end

                default: begin
                    state     <= COLLECT;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_in_loader.sv
// -----------------------------------------------------------------------------
// tb_aes_in_loader
//
// Drives two loader instances from one byte stream: index 0 is KEY_STICKY=1
// with a 2-bit counter (so wrap is reachable), index 1 is KEY_STICKY=0 with a
// 16-bit counter. Each instance has its own reference model that tracks the
// collected bytes as arrays plus a few flags (block full, pair pending).
// -----------------------------------------------------------------------------
module tb_aes_in_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [7:0]   in_byte;
    logic         in_is_key;
    logic         in_valid;
    logic         out_ready;

    logic         rdy_s, rdy_n;
    logic [0:127] dat_s, dat_n, key_s, key_n;
    logic         ov_s, ov_n, kv_s, kv_n;
    logic [1:0]   cnt_s;
    logic [15:0]  cnt_n;

    aes_in_loader #(.KEY_STICKY(1'b1), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_is_key(in_is_key),
        .in_valid(in_valid), .in_ready(rdy_s), .data_out(dat_s), .key_out(key_s),
        .out_valid(ov_s), .out_ready(out_ready), .key_valid(kv_s), .blk_cnt(cnt_s)
    );

    aes_in_loader #(.KEY_STICKY(1'b0), .CNT_W(16)) dut_n (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_is_key(in_is_key),
        .in_valid(in_valid), .in_ready(rdy_n), .data_out(dat_n), .key_out(key_n),
        .out_valid(ov_n), .out_ready(out_ready), .key_valid(kv_n), .blk_cnt(cnt_n)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state, one entry per instance.
    logic [7:0] m_key [2][16];
    logic [7:0] m_dat [2][16];
    int         m_kc  [2];
    int         m_dc  [2];
    bit         m_kok [2];   // complete key held
    bit         m_full[2];   // 16 data bytes held, no key yet
    bit         m_pend[2];   // pair offered, not yet taken
    int         m_blk [2];
    bit         m_acc [2];   // byte accepted on the last clock

    logic last_rdy_s, last_rdy_n;

    function automatic bit model_ready(int i, bit k);
        return !m_pend[i] && (!m_full[i] || k);
    endfunction

    function automatic logic [127:0] model_key(int i);
        logic [127:0] r = '0;
        for (int j = 0; j < 16; j++) r = (r << 8) | 128'(m_key[i][j]);
        return r;
    endfunction

    function automatic logic [127:0] model_dat(int i);
        logic [127:0] r = '0;
        for (int j = 0; j < 16; j++) r = (r << 8) | 128'(m_dat[i][j]);
        return r;
    endfunction

    function automatic logic [127:0] pack16(input logic [7:0] b [16]);
        logic [127:0] r = '0;
        for (int j = 0; j < 16; j++) r = (r << 8) | 128'(b[j]);
        return r;
    endfunction

    task automatic model_step(int i, bit r, bit v, bit k, logic [7:0] b, bit ordy);
        m_acc[i] = 1'b0;
        if (r) begin
            for (int j = 0; j < 16; j++) begin
                m_key[i][j] = 8'h00;
                m_dat[i][j] = 8'h00;
            end
            m_kc[i] = 0; m_dc[i] = 0; m_kok[i] = 0; m_full[i] = 0;
            m_pend[i] = 0; m_blk[i] = 0;
            return;
        end
        if (m_pend[i]) begin
            if (ordy) begin
                m_pend[i] = 0;
                m_blk[i]++;
                if (i == 1) m_kok[i] = 0;
            end
            return;
        end
        if (v && model_ready(i, k)) begin
            m_acc[i] = 1'b1;
            if (k) begin
                m_key[i][m_kc[i]] = b;
                if (m_kc[i] == 0) m_kok[i] = 0;
                m_kc[i]++;
                if (m_kc[i] == 16) begin m_kc[i] = 0; m_kok[i] = 1; end
            end else begin
                m_dat[i][m_dc[i]] = b;
                m_dc[i]++;
                if (m_dc[i] == 16) begin m_dc[i] = 0; m_full[i] = 1; end
            end
        end
        if (m_full[i] && m_kok[i]) begin
            m_full[i] = 0;
            m_pend[i] = 1;
        end
    endtask

    // One clock: drive at negedge, check in_ready before the edge, step the
    // models on the edge, check registered outputs at the next negedge.
    task automatic tick(bit r, bit v, bit k, logic [7:0] b, bit ordy);
        rst = r; in_valid = v; in_is_key = k; in_byte = b; out_ready = ordy;
        #1;
        last_rdy_s = rdy_s;
        last_rdy_n = rdy_n;
        for (int i = 0; i < 2; i++) begin
            logic g = (i == 0) ? rdy_s : rdy_n;
            logic e = model_ready(i, k);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL in_ready[%0d] t=%0t got=%b exp=%b", i, $time, g, e);
            end
        end
        @(posedge clk);
        model_step(0, r, v, k, b, ordy);
        model_step(1, r, v, k, b, ordy);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            logic         g_ov = (i == 0) ? ov_s : ov_n;
            logic         g_kv = (i == 0) ? kv_s : kv_n;
            logic [0:127] g_d  = (i == 0) ? dat_s : dat_n;
            logic [0:127] g_k  = (i == 0) ? key_s : key_n;
            logic [15:0]  g_c  = (i == 0) ? 16'(cnt_s) : cnt_n;
            logic [15:0]  e_c  = (i == 0) ? 16'(m_blk[0] % 4) : 16'(m_blk[1] % 65536);
            logic [0:127] e_d  = model_dat(i);
            logic [0:127] e_k  = model_key(i);
            checks++;
            if (g_ov !== m_pend[i]) begin
                failures++;
                $display("FAIL out_valid[%0d] t=%0t got=%b exp=%b", i, $time, g_ov, m_pend[i]);
            end
            checks++;
            if (g_kv !== m_kok[i]) begin
                failures++;
                $display("FAIL key_valid[%0d] t=%0t got=%b exp=%b", i, $time, g_kv, m_kok[i]);
            end
            checks++;
            if (g_c !== e_c) begin
                failures++;
                $display("FAIL blk_cnt[%0d] t=%0t got=%0d exp=%0d", i, $time, g_c, e_c);
            end
            checks++;
            if (g_d !== e_d) begin
                failures++;
                $display("FAIL data_out[%0d] t=%0t got=%h exp=%h", i, $time, g_d, e_d);
            end
            checks++;
            if (g_k !== e_k) begin
                failures++;
                $display("FAIL key_out[%0d] t=%0t got=%h exp=%h", i, $time, g_k, e_k);
            end
        end
    endtask

    // Present one byte until the chosen instance's model accepts it.
    task automatic send(int idx, bit k, logic [7:0] b);
        for (int t = 0; t < 40; t++) begin
            tick(1'b0, 1'b1, k, b, 1'b0);
            if (m_acc[idx]) return;
        end
        checks++;
        failures++;
        $display("FAIL send_timeout idx=%0d key=%b byte=%h not accepted in 40 cycles", idx, k, b);
    endtask

    task automatic load_key(int idx, input logic [7:0] kb [16]);
        for (int j = 0; j < 16; j++) send(idx, 1'b1, kb[j]);
    endtask

    task automatic load_data(int idx, input logic [7:0] db [16]);
        for (int j = 0; j < 16; j++) send(idx, 1'b0, db[j]);
    endtask

    task automatic rand_bytes(output logic [7:0] b [16]);
        for (int j = 0; j < 16; j++) b[j] = 8'($urandom);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_bit(string name, logic got, logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
        end
    endtask

    task automatic check_vec(string name, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_is_key = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_step(0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        model_step(1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        do_reset();
        check_bit("reset_out_valid", ov_s, 1'b0);
        check_bit("reset_key_valid", kv_s, 1'b0);
        check_vec("reset_data_out", dat_s, 128'h0);
        check_vec("reset_key_out", key_s, 128'h0);
        check_vec("reset_blk_cnt", 128'(cnt_n), 128'h0);
    endtask

    task automatic test_fips();
        logic [7:0] kb [16];
        logic [7:0] db [16];
        for (int j = 0; j < 16; j++) begin
            kb[j] = 8'(j);
            db[j] = 8'(j * 17);
        end
        do_reset();
        load_key(0, kb);
        load_data(0, db);
        check_bit("fips_out_valid", ov_s, 1'b1);
        check_vec("fips_data_out", dat_s, 128'h00112233445566778899aabbccddeeff);
        check_vec("fips_key_out", key_s, 128'h000102030405060708090a0b0c0d0e0f);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_bit("fips_out_valid_drop", ov_s, 1'b0);
    endtask

    task automatic test_data_before_key();
        logic [7:0] kb [16];
        logic [7:0] db [16];
        rand_bytes(kb);
        rand_bytes(db);
        do_reset();
        load_data(0, db);
        check_bit("dbk_no_valid", ov_s, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 8'h5a, 1'b0);
        check_bit("dbk_data_stall", last_rdy_s, 1'b0);
        tick(1'b0, 1'b1, 1'b1, kb[0], 1'b0);
        check_bit("dbk_key_flows", last_rdy_s, 1'b1);
        for (int j = 1; j < 16; j++) send(0, 1'b1, kb[j]);
        check_bit("dbk_out_valid", ov_s, 1'b1);
        check_vec("dbk_data_out", dat_s, pack16(db));
        check_vec("dbk_key_out", key_s, pack16(kb));
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_sticky();
        logic [7:0] kb [16];
        logic [7:0] db [16];
        rand_bytes(kb);
        do_reset();
        load_key(0, kb);
        for (int n = 0; n < 3; n++) begin
            rand_bytes(db);
            load_data(0, db);
            check_bit("sticky_out_valid", ov_s, 1'b1);
            tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            check_bit("sticky_key_valid", kv_s, 1'b1);
        end
        check_vec("sticky_blk_cnt", 128'(cnt_s), 128'd3);
    endtask

    task automatic test_nonsticky();
        logic [7:0] kb [16];
        logic [7:0] db [16];
        rand_bytes(kb);
        rand_bytes(db);
        do_reset();
        load_key(1, kb);
        load_data(1, db);
        check_bit("ns_out_valid1", ov_n, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_bit("ns_key_dropped", kv_n, 1'b0);
        check_vec("ns_blk_cnt1", 128'(cnt_n), 128'd1);
        rand_bytes(db);
        load_data(1, db);
        check_bit("ns_held", ov_n, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 8'hc3, 1'b0);
        check_bit("ns_data_stall", last_rdy_n, 1'b0);
        rand_bytes(kb);
        load_key(1, kb);
        check_bit("ns_out_valid2", ov_n, 1'b1);
        check_vec("ns_data_out2", dat_n, pack16(db));
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_vec("ns_blk_cnt2", 128'(cnt_n), 128'd2);
    endtask

    task automatic test_backpressure();
        logic [7:0] kb [16];
        logic [7:0] db [16];
        rand_bytes(kb);
        rand_bytes(db);
        do_reset();
        load_key(0, kb);
        load_data(0, db);
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 1'b1, 1'($urandom), 8'($urandom), 1'b0);
            check_bit("bp_out_valid", ov_s, 1'b1);
            check_bit("bp_in_ready", last_rdy_s, 1'b0);
            check_vec("bp_data_out", dat_s, pack16(db));
            check_vec("bp_key_out", key_s, pack16(kb));
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_bit("bp_drop", ov_s, 1'b0);
    endtask

    task automatic test_reset_midload();
        logic [7:0] kb [16];
        logic [7:0] db [16];
        rand_bytes(kb);
        rand_bytes(db);
        do_reset();
        load_key(0, kb);
        for (int j = 0; j < 7; j++) send(0, 1'b0, 8'($urandom));
        do_reset();
        check_vec("rml_data_cleared", dat_s, 128'h0);
        check_bit("rml_no_valid", ov_s, 1'b0);
        load_key(0, kb);
        load_data(0, db);
        check_bit("rml_out_valid", ov_s, 1'b1);
        check_vec("rml_data_fresh", dat_s, pack16(db));
        check_vec("rml_blk_before", 128'(cnt_s), 128'd0);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_vec("rml_blk_after", 128'(cnt_s), 128'd1);
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            bit r  = ($urandom_range(0, 399) == 0);
            bit v  = ($urandom_range(0, 3) != 0);
            bit k  = ($urandom_range(0, 9) < 4);
            bit od = ($urandom_range(0, 1) == 1);
            tick(r, v, k, 8'($urandom), od);
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_data_before_key();
        test_sticky();
        test_nonsticky();
        test_backpressure();
        test_reset_midload();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
